aidc_lite_decomp_zmask: RTL and testbench
=========================================

// Module: aidc_lite_decomp_zmask
// PURPOSE
//  Parametrised zero-mask decompressor, next generation of the AIDC-Lite ZRLE decoder.
//  - Accepts a packed code stream, IN_W bits per beat, with input backpressure.
//  - Rebuilds BEATS output beats per block; each beat is LANES words of WORD_W bits.
//  - Writes each beat to a shared, OR-combined block buffer by address.
//  - Sits in the AIDC-Lite decompression path, in parallel with the other decompressors.
// PARAMETERS
//  IN_W    32   input code beat width (bits)
//  WORD_W  16   width of one data word
//  LANES   4    words per output beat; also the zero-mask width
//  BEATS   8    output beats per block; ADDR_W = $clog2(BEATS) (localparam)
//  HDR_W   2    prefix bits at the top of the sop beat, discarded
//  BUF_W   512  code buffer depth (bits); must be >= LANES*(WORD_W+1)+IN_W
// PORTS
//  clk      in   1              clock
//  rst_n    in   1              reset: synchronous, active-low
//  valid_i  in   1              input code beat valid
//  ready_o  out  1              input may be accepted this cycle
//  sop_i    in   1              first beat of a block
//  eop_i    in   1              last beat of a block
//  data_i   in   IN_W           code bits, MSB first
//  valid_o  out  1              output write strobe
//  addr_o   out  ADDR_W         output beat index within the block
//  data_o   out  LANES*WORD_W   reconstructed beat; lane LANES-1 is in the MSBs
//  done_o   out  1              block complete (sticky until next sop)
//  err_o    out  1              only with AIDC_ZMASK_ERR_CHK_EN
// BEHAVIOUR
//  Code format: per beat, a LANES-bit mask, MSB = lane LANES-1, 1 = nonzero.
//   - The mask is followed by popcount(mask) words of WORD_W bits each.
//   - Words are in descending lane order. Lanes with mask bit 0 output 0.
//  Buffer: code_buf is left-aligned; buf_size counts valid bits (0..BUF_W).
//  Accept rule: a beat is accepted when valid_i && ready_o.
//   - ready_o = (buf_size <= BUF_W-IN_W), taken from the registered buf_size.
//   - ready_o is forced 1 when sop_i=1.
//   - valid_i is ignored while ready_o=0; the source holds the beat.
//  Sop accept:
//   - code_buf top IN_W-HDR_W bits = data_i[IN_W-HDR_W-1:0]; all other bits cleared.
//   - buf_size = IN_W-HDR_W; cnt = 0; done = 0.
//   - Any decode in the same cycle is discarded.
//  Non-sop accept:
//   - Data is appended at the bit offset equal to post-decode buf_size.
//   - buf_size += IN_W.
//   - A decode and an append in the same cycle are both honoured.
//  Decode: at most one beat per cycle, from the registered buffer.
//   - Decode requires cnt < BEATS and buf_size >= LANES + popcount(mask)*WORD_W.
//   - On decode: buffer shifts left by that amount; buf_size decreases by it; cnt += 1.
//  Latency: valid_o asserts 2 cycles after the accept of the beat that completes a code.
//   - Throughput: 1 output beat per cycle when the buffer holds enough bits.
//  Outputs are registered.
//   - When valid_o=1: addr_o = cnt before increment.
//   - When valid_o=0: addr_o and data_o are 0, because the bus is OR-shared.
//   - done_o rises in the same cycle as the valid_o of addr BEATS-1.
//   - done_o holds until the next sop is accepted.
//  After cnt = BEATS:
//   - No further decode occurs.
//   - Residual bits (padding) are left in the buffer and flushed at the next sop.
//   - eop_i is informational, except with the error check (see CONFIGURATION).
//  Reset values: valid_o=0, addr_o=0, data_o=0, done_o=0, err_o=0.
//   - Internal reset values: buf_size=0, cnt=0.
//   - ready_o=1 after reset. A reset mid-block abandons the block with no output.
//  Widths: buf_size and the shift amounts are $clog2(BUF_W+1) bits, with no wrap.
//   - cnt is $clog2(BEATS+1) bits and saturates at BEATS.
// CONFIGURATION
//  AIDC_ZMASK_ERR_CHK_EN defined: adds err_o, a sticky error flag cleared on sop accept.
//   - Overrun sets err_o: a non-sop beat accepted while done=1, or before any sop.
//   - Truncation sets err_o: eop has been accepted, cnt < BEATS, and the buffer
//     cannot supply the next beat.
//  Not defined: no err_o port and no check logic; those cases decode silently.
// TESTING
//  1 All-zero block: sop 0x0000_0000, then 0x0000_0000 with eop
//    -> valid_o 8 cycles, addr 0..7, data 0; done_o with addr 7.
//  2 Dense beat: sop 0x3C00_0000 (mask 1111), then 64 data bits 0x1111,0x2222,0x3333,0x4444
//    -> addr 0 data 0x1111_2222_3333_4444.
//  3 Sparse beat: mask 0101, words 0xAAAA,0x5555
//    -> data 0x0000_AAAA_0000_5555; lone mask 1000 word 0xBEEF -> 0xBEEF_0000_0000_0000.
//  4 Backpressure: BUF_W=128, valid_i held 1 for a dense block
//    -> ready_o drops; all 8 beats are exact; no beat is lost or duplicated.
//  5 Sop after 3 beats decoded
//    -> next addr_o=0, done_o=0, old bits gone.
//  6 Reset mid-block, then a new block
//    -> outputs 0 and the new block decodes correctly.
//  7 ERR_CHK_EN: eop after 4 beats of codes -> err_o=1, sticky; extra beat after done -> err_o=1.

Source files
------------

// File: rtl/aidc_lite_decomp_zmask.sv
// aidc_lite_decomp_zmask: zero-mask block decompressor, packed code stream in, addressed beat writes out
//   clk, rst_n         clock, synchronous active-low reset
//   valid_i/ready_o    code beat handshake (ready forced high on sop_i)
//   sop_i/eop_i        block delimiters on the input stream
//   data_i             IN_W code bits, MSB first
//   valid_o/addr_o     write strobe and beat index within the block
//   data_o             rebuilt beat, lane LANES-1 in the MSBs, zero when idle
//   done_o             block complete, sticky until the next sop
//   err_o              overrun/truncation flag, only with AIDC_ZMASK_ERR_CHK_EN
module aidc_lite_decomp_zmask #(
  parameter int IN_W   = 32,
  parameter int WORD_W = 16,
  parameter int LANES  = 4,
  parameter int BEATS  = 8,
  parameter int HDR_W  = 2,
  parameter int BUF_W  = 512,
  localparam int ADDR_W = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    sop_i,
  input  logic                    eop_i,
  input  logic [IN_W-1:0]         data_i,
  output logic                    valid_o,
  output logic [ADDR_W-1:0]       addr_o,
  output logic [LANES*WORD_W-1:0] data_o,
  output logic                    done_o
`ifdef AIDC_ZMASK_ERR_CHK_EN
  ,
  output logic                    err_o
`endif
);
  localparam int SZ_W  = $clog2(BUF_W+1);
  localparam int CNT_W = $clog2(BEATS+1);
  localparam int PC_W  = $clog2(LANES+1);
  logic [BUF_W-1:0] code_buf, sh_buf, nxt_buf, wbuf;
  logic [SZ_W-1:0] buf_size, need, sz_post;
  logic [CNT_W-1:0] cnt;
  logic [LANES-1:0] mask;
  logic [PC_W-1:0] pc;
  logic [LANES*WORD_W-1:0] beat;
  logic dec, acc;
  assign mask = code_buf[BUF_W-1 -: LANES];
  // words follow the mask in descending lane order; peel them off the top
  always_comb begin
    pc = '0;
    beat = '0;
    wbuf = code_buf << LANES;
    for (int l = LANES-1; l >= 0; l--)
      if (mask[l]) begin
        beat[l*WORD_W +: WORD_W] = wbuf[BUF_W-1 -: WORD_W];
        wbuf = wbuf << WORD_W;
        pc = pc + 1'b1;
      end
  end
  assign need    = SZ_W'(LANES) + SZ_W'(pc) * SZ_W'(WORD_W);
  assign dec     = (cnt < CNT_W'(BEATS)) && (buf_size >= need);
  assign sz_post = dec ? buf_size - need : buf_size;
  assign sh_buf  = dec ? code_buf << need : code_buf;
  assign ready_o = sop_i || (buf_size <= SZ_W'(BUF_W-IN_W));
  assign acc     = valid_i && ready_o;
  // bits below buf_size are always zero, so appending is a plain OR
  assign nxt_buf = sh_buf | ({data_i, {(BUF_W-IN_W){1'b0}}} >> sz_post);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_buf <= '0;
      buf_size <= '0;
      cnt      <= '0;
      valid_o  <= 1'b0;
      addr_o   <= '0;
      data_o   <= '0;
      done_o   <= 1'b0;
    end else if (acc && sop_i) begin
      code_buf <= {data_i[IN_W-HDR_W-1:0], {(BUF_W-IN_W+HDR_W){1'b0}}};
      buf_size <= SZ_W'(IN_W-HDR_W);
      cnt      <= '0;
      valid_o  <= 1'b0;
      addr_o   <= '0;
      data_o   <= '0;
      done_o   <= 1'b0;
    end else begin
      code_buf <= acc ? nxt_buf : sh_buf;
      buf_size <= acc ? sz_post + SZ_W'(IN_W) : sz_post;
      cnt      <= dec ? cnt + 1'b1 : cnt;
      valid_o  <= dec;
      addr_o   <= dec ? cnt[ADDR_W-1:0] : '0;
      data_o   <= dec ? beat : '0;
      done_o   <= done_o || (dec && cnt == CNT_W'(BEATS-1));
    end
  end
`ifdef AIDC_ZMASK_ERR_CHK_EN
  logic seen_sop, eop_seen;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_o    <= 1'b0;
      seen_sop <= 1'b0;
      eop_seen <= 1'b0;
    end else if (acc && sop_i) begin
      err_o    <= 1'b0;
      seen_sop <= 1'b1;
      eop_seen <= eop_i;
    end else begin
      err_o    <= err_o || (acc && (done_o || !seen_sop)) || (eop_seen && cnt < CNT_W'(BEATS) && !dec);
      eop_seen <= eop_seen || (acc && eop_i);
    end
  end
`endif
endmodule

// File: tb/tb_aidc_lite_decomp_zmask.sv
// tb_aidc_lite_decomp_zmask: table-driven bench for the zero-mask decompressor
module tb_aidc_lite_decomp_zmask;
  logic clk = 0, rst_n = 0, valid_i = 0, sop_i = 0, eop_i = 0;
  logic [31:0] data_i = '0;
  logic ready_o, valid_o, done_o;
  logic [2:0] addr_o;
  logic [63:0] data_o;
`ifdef AIDC_ZMASK_ERR_CHK_EN
  logic err_o;
`endif
  always #5 clk = ~clk;
  aidc_lite_decomp_zmask #(.BUF_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .sop_i(sop_i), .eop_i(eop_i), .data_i(data_i), .valid_o(valid_o),
    .addr_o(addr_o), .data_o(data_o), .done_o(done_o)
`ifdef AIDC_ZMASK_ERR_CHK_EN
    , .err_o(err_o)
`endif
  );
  typedef struct {
    logic [3:0]  mask;
    logic [63:0] wds;
    logic [63:0] exp;
  } rec_t;
  rec_t recs [24];
  int errors = 0, checks = 0;
  logic saw_busy;
  logic [0:1023] bs;
  int nb;
  logic [63:0] cap_data [$];
  logic [2:0]  cap_addr [$];
  logic        cap_done [$];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic rec_t mk(input logic [3:0] m, input logic [63:0] w, input logic [63:0] e);
    rec_t r;
    r.mask = m;
    r.wds = w;
    r.exp = e;
    return r;
  endfunction
  always @(negedge clk)
    if (rst_n && valid_o) begin
      cap_data.push_back(data_o);
      cap_addr.push_back(addr_o);
      cap_done.push_back(done_o);
    end else if (rst_n)
      check("idle_bus", data_o | 64'(addr_o), 64'h0);
  task automatic push_bits(input logic [63:0] v, input int w);
    for (int i = w-1; i >= 0; i--) begin
      bs[nb] = v[i];
      nb++;
    end
  endtask
  task automatic build(input int first, input int last, input logic pad, output int nbeats);
    bs = pad ? '1 : '0;
    nb = 0;
    for (int r = first; r <= last; r++) begin
      int k = 0;
      push_bits(64'(recs[r].mask), 4);
      for (int j = 3; j >= 0; j--)
        if (recs[r].mask[j]) begin
          push_bits(64'(recs[r].wds[63-16*k -: 16]), 16);
          k++;
        end
    end
    nbeats = (nb <= 30) ? 1 : 1 + (nb - 30 + 31) / 32;
  endtask
  function automatic logic [31:0] beat(input int k);
    return (k == 0) ? {2'b11, bs[0:29]} : bs[30+32*(k-1) +: 32];
  endfunction
  task automatic drive_beat(input logic s, input logic e, input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    valid_i = 1; sop_i = s; eop_i = e; data_i = d;
    #1;
    while (!ready_o && t < 200) begin
      saw_busy = 1;
      @(negedge clk);
      #1;
      t++;
    end
    if (!ready_o) check("ready_timeout", 64'(ready_o), 64'h1);
    @(posedge clk);
  endtask
  task automatic idle();
    @(negedge clk);
    valid_i = 0; sop_i = 0; eop_i = 0; data_i = '0;
  endtask
  task automatic send(input int first, input int last, input logic pad, input int nsend, input logic keep);
    int nbeats, n;
    build(first, last, pad, nbeats);
    n = (nsend < 0) ? nbeats : nsend;
    for (int k = 0; k < n; k++) drive_beat(k == 0, k == nbeats-1, beat(k));
    if (!keep) idle();
  endtask
  task automatic expect_block(input int first, input int n);
    int t = 0;
    while (cap_data.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("beat_count", 64'(cap_data.size()), 64'(n));
    for (int i = 0; i < n && i < cap_data.size(); i++) begin
      check($sformatf("addr[%0d]", first+i), 64'(cap_addr[i]), 64'(i));
      check($sformatf("data[%0d]", first+i), cap_data[i], recs[first+i].exp);
      check($sformatf("done[%0d]", first+i), 64'(cap_done[i]), 64'(i == 7));
    end
    cap_data.delete(); cap_addr.delete(); cap_done.delete();
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    recs[0]  = mk(4'b1111, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444);
    recs[1]  = mk(4'b0101, 64'hAAAA_5555_0000_0000, 64'h0000_AAAA_0000_5555);
    recs[2]  = mk(4'b1000, 64'hBEEF_0000_0000_0000, 64'hBEEF_0000_0000_0000);
    recs[3]  = mk(4'b0000, 64'h0,                   64'h0);
    recs[4]  = mk(4'b0001, 64'h1234_0000_0000_0000, 64'h0000_0000_0000_1234);
    recs[5]  = mk(4'b0110, 64'hCAFE_F00D_0000_0000, 64'h0000_CAFE_F00D_0000);
    recs[6]  = mk(4'b1111, 64'hDEAD_BEEF_0001_8000, 64'hDEAD_BEEF_0001_8000);
    recs[7]  = mk(4'b1001, 64'h7777_9999_0000_0000, 64'h7777_0000_0000_9999);
    recs[8]  = mk(4'b1111, 64'hA001_A002_A003_A004, 64'hA001_A002_A003_A004);
    recs[9]  = mk(4'b1111, 64'hB011_B012_B013_B014, 64'hB011_B012_B013_B014);
    recs[10] = mk(4'b1111, 64'hC021_C022_C023_C024, 64'hC021_C022_C023_C024);
    recs[11] = mk(4'b1111, 64'hD031_D032_D033_D034, 64'hD031_D032_D033_D034);
    recs[12] = mk(4'b1111, 64'hE041_E042_E043_E044, 64'hE041_E042_E043_E044);
    recs[13] = mk(4'b1111, 64'hF051_F052_F053_F054, 64'hF051_F052_F053_F054);
    recs[14] = mk(4'b1111, 64'h0161_0262_0363_0464, 64'h0161_0262_0363_0464);
    recs[15] = mk(4'b1111, 64'h8071_9072_A073_B074, 64'h8071_9072_A073_B074);
    for (int i = 16; i < 24; i++) recs[i] = mk(4'b0000, 64'h0, 64'h0);
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(valid_o), 64'h0);
    check("rst_addr",  64'(addr_o),  64'h0);
    check("rst_data",  data_o,       64'h0);
    check("rst_done",  64'(done_o),  64'h0);
    check("rst_ready", 64'(ready_o), 64'h1);
    rst_n = 1;
    send(16, 23, 0, -1, 0);
    expect_block(16, 8);
    check("done_hold", 64'(done_o), 64'h1);
    send(0, 7, 1, -1, 0);
    expect_block(0, 8);
    saw_busy = 0;
    send(8, 15, 1, -1, 1);
    repeat (8) begin
      @(negedge clk);
      valid_i = 1; sop_i = 0; eop_i = 0; data_i = '0;
      #1;
      if (!ready_o) saw_busy = 1;
    end
    idle();
    expect_block(8, 8);
    check("ready_dropped", 64'(saw_busy), 64'h1);
    send(0, 7, 1, 4, 0);
    expect_block(0, 3);
    send(8, 15, 1, -1, 0);
    expect_block(8, 8);
    send(8, 15, 1, 3, 0);
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("midrst_valid", 64'(valid_o), 64'h0);
    check("midrst_data",  data_o | 64'(addr_o), 64'h0);
    check("midrst_done",  64'(done_o),  64'h0);
    check("midrst_ready", 64'(ready_o), 64'h1);
    rst_n = 1;
    cap_data.delete(); cap_addr.delete(); cap_done.delete();
    send(0, 7, 1, -1, 0);
    expect_block(0, 8);
`ifdef AIDC_ZMASK_ERR_CHK_EN
    send(0, 3, 1, -1, 0);
    expect_block(0, 4);
    check("err_trunc", 64'(err_o), 64'h1);
    repeat (5) @(negedge clk);
    check("err_sticky", 64'(err_o), 64'h1);
    send(16, 23, 0, -1, 0);
    expect_block(16, 8);
    check("err_clear", 64'(err_o), 64'h0);
    drive_beat(0, 0, 32'h0);
    idle();
    repeat (2) @(negedge clk);
    check("err_overrun", 64'(err_o), 64'h1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
